// File: rtl/sevenseg_scan.sv
// Four-digit seven-segment scanner: steps through digits at a fixed slot rate,
// blanks each slot's leading edge, and swaps in a new hex value only at frame ends.
module sevenseg_scan #(
    parameter int unsigned PRESCALE    = 50000,
    parameter int unsigned DEAD        = 16,
    parameter int unsigned LZ_SUPPRESS = 0
) (
    input  logic        system1000,
    input  logic        system1000_rst,
    input  logic [15:0] value_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [1:0]  digit_o,
    output logic        an_en_o,
    output logic [6:0]  seg_o
);

    localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(PRESCALE - 1);
    localparam logic [CntW-1:0] DeadCnt = CntW'(DEAD);

    logic [CntW-1:0] cnt;
    logic [1:0]      dig;
    logic [15:0]     disp;
    logic [15:0]     pend;
    logic            pendFull;

    logic            slotEnd;
    logic            frameEnd;
    logic            accept;

    assign slotEnd  = (cnt == LastCnt);
    assign frameEnd = slotEnd && (dig == 2'd3);
    assign accept   = valid_i && !pendFull;

    // Slot/digit scan plus the pending-to-display handoff at frame ends.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            cnt      <= '0;
            dig      <= 2'd0;
            disp     <= 16'd0;
            pend     <= 16'd0;
            pendFull <= 1'b0;
        end else begin
            cnt <= slotEnd ? '0 : cnt + CntW'(1);
            if (slotEnd) begin
                dig <= dig + 2'd1;
            end
            // A full buffer keeps ready low, so a transfer and an accept never collide.
            if (frameEnd && pendFull) begin
                disp     <= pend;
                pendFull <= 1'b0;
            end else if (accept) begin
                pend     <= value_i;
                pendFull <= 1'b1;
            end
        end
    end

    logic [3:0] nibble;
    logic [6:0] pattern;
    logic       lzBlank;

    // Output decode from registered state only.
    always_comb begin
        nibble  = disp[{dig, 2'b00} +: 4];
        lzBlank = (LZ_SUPPRESS != 0) && (dig != 2'd0) && ((disp >> {dig, 2'b00}) == 16'd0);
        pattern = 7'h00;
        case (nibble)
            4'h0: pattern = 7'h3F;
            4'h1: pattern = 7'h06;
            4'h2: pattern = 7'h5B;
            4'h3: pattern = 7'h4F;
            4'h4: pattern = 7'h66;
            4'h5: pattern = 7'h6D;
            4'h6: pattern = 7'h7D;
            4'h7: pattern = 7'h07;
            4'h8: pattern = 7'h7F;
            4'h9: pattern = 7'h6F;
            4'hA: pattern = 7'h77;
            4'hB: pattern = 7'h7C;
            4'hC: pattern = 7'h39;
            4'hD: pattern = 7'h5E;
            4'hE: pattern = 7'h79;
            default: pattern = 7'h71;
        endcase
    end

    assign ready_o = !pendFull;
    assign digit_o = dig;
    assign an_en_o = (cnt >= DeadCnt) && !lzBlank;
    assign seg_o   = an_en_o ? pattern : 7'h00;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: directed frame scenarios plus random offers, checked
// every cycle against a time-based model of the scan and frame handoff.
module tb_sevenseg_scan;

    localparam int P     = 8;
    localparam int D     = 2;
    localparam int FRAME = 4 * P;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [15:0] value;
    logic        ready0, ready1, an0, an1;
    logic [1:0]  digit0, digit1;
    logic [6:0]  seg0, seg1;

    always #5 clk = ~clk;

    sevenseg_scan #(.PRESCALE(P), .DEAD(D), .LZ_SUPPRESS(0)) u0 (
        .system1000(clk), .system1000_rst(rst), .value_i(value), .valid_i(valid),
        .ready_o(ready0), .digit_o(digit0), .an_en_o(an0), .seg_o(seg0));

    sevenseg_scan #(.PRESCALE(P), .DEAD(D), .LZ_SUPPRESS(1)) u1 (
        .system1000(clk), .system1000_rst(rst), .value_i(value), .valid_i(valid),
        .ready_o(ready1), .digit_o(digit1), .an_en_o(an1), .seg_o(seg1));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Model: time since reset release, displayed value, pending slot.
    int          tick;
    logic [15:0] mDisp;
    logic [15:0] mPend;
    bit          mPendFull;
    bit          lastAcc;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tbl[n];
    endfunction

    function automatic int curDigit();
        return (tick / P) % 4;
    endfunction

    function automatic bit expAn(input bit lz);
        int d;
        bit blank;
        d = curDigit();
        blank = lz && (d != 0) && ((int'(mDisp) >> (4 * d)) == 0);
        return ((tick % P) >= D) && !blank;
    endfunction

    function automatic logic [6:0] expSeg(input bit lz);
        int d;
        d = curDigit();
        return expAn(lz) ? hex7(4'((int'(mDisp) >> (4 * d)) & 15)) : 7'h00;
    endfunction

    task automatic checkAll();
        chk("ready0", 32'(ready0), 32'(!mPendFull));
        chk("ready1", 32'(ready1), 32'(!mPendFull));
        chk("digit0", 32'(digit0), 32'(curDigit()));
        chk("digit1", 32'(digit1), 32'(curDigit()));
        chk("an0", 32'(an0), 32'(expAn(1'b0)));
        chk("an1", 32'(an1), 32'(expAn(1'b1)));
        chk("seg0", 32'(seg0), 32'(expSeg(1'b0)));
        chk("seg1", 32'(seg1), 32'(expSeg(1'b1)));
    endtask

    // One clock: advance the model from pre-edge state and inputs, then check.
    task automatic step();
        bit boundary;
        bit acc;
        bit r;
        boundary = (tick % FRAME) == (FRAME - 1);
        acc      = valid && !mPendFull;
        r        = rst;
        @(posedge clk);
        #1;
        lastAcc = 1'b0;
        if (r) begin
            tick      = 0;
            mDisp     = 16'h0000;
            mPendFull = 1'b0;
        end else begin
            if (boundary && mPendFull) begin
                mDisp     = mPend;
                mPendFull = 1'b0;
            end
            if (acc) begin
                mPend     = value;
                mPendFull = 1'b1;
                lastAcc   = 1'b1;
            end
            tick++;
        end
        checkAll();
    endtask

    task automatic runTo(input int target);
        while (tick < target) step();
    endtask

    task automatic offer(input logic [15:0] v);
        valid = 1'b1;
        value = v;
        step();
        chk("offer_acc", 32'(lastAcc), 32'd1);
        valid = 1'b0;
    endtask

    initial begin
        int guard;
        tick  = 0;
        mDisp = 16'h0000;
        mPend = 16'h0000;
        mPendFull = 1'b0;
        rst   = 1'b1;
        valid = 1'b0;
        value = 16'h0000;

        // Reset and idle scan
        repeat (3) step();
        chk("rst_ready", 32'(ready0), 32'd1);
        chk("rst_seg", 32'(seg0), 32'h00);
        chk("rst_an", 32'(an0), 32'd0);
        rst = 1'b0;
        runTo(1);
        chk("dead_an", 32'(an0), 32'd0);
        runTo(2);
        chk("rise_an", 32'(an0), 32'd1);
        chk("rise_seg", 32'(seg0), 32'h3F);
        runTo(8);
        chk("dig_step", 32'(digit0), 32'd1);
        runTo(32);
        chk("dig_wrap", 32'(digit0), 32'd0);

        // Accept 0x1A2F mid-frame and apply at the boundary
        runTo(40);
        offer(16'h1A2F);
        chk("acc_ready", 32'(ready0), 32'd0);
        runTo(64);
        chk("bnd_ready", 32'(ready0), 32'd1);
        runTo(66); chk("v1_d0", 32'(seg0), 32'h71);
        runTo(74); chk("v1_d1", 32'(seg0), 32'h5B);
        runTo(82); chk("v1_d2", 32'(seg0), 32'h77);
        runTo(90); chk("v1_d3", 32'(seg0), 32'h06);

        // Back-pressure: 0x2222 held until the buffer drains
        offer(16'h1111);
        valid = 1'b1;
        value = 16'h2222;
        guard = 0;
        lastAcc = 1'b0;
        while (!lastAcc && guard < 100) begin
            step();
            guard++;
        end
        chk("bp_acc_tick", 32'(tick), 32'd97);
        valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            runTo(96 + k * P + D);
            chk("bp_mid", 32'(seg0), 32'h06);
        end
        runTo(130); chk("bp_new_d0", 32'(seg0), 32'h5B);
        runTo(154); chk("bp_new_d3", 32'(seg0), 32'h5B);

        // Accept exactly on the boundary cycle
        runTo(159);
        offer(16'hBEEF);
        runTo(162); chk("ba_old", 32'(seg0), 32'h5B);
        runTo(194); chk("ba_new_d0", 32'(seg0), 32'h71);
        runTo(218); chk("ba_new_d3", 32'(seg0), 32'h7C);

        // Leading-zero suppression
        runTo(200);
        offer(16'h0040);
        runTo(226); chk("lz_d0", 32'(seg1), 32'h3F);
        runTo(234); chk("lz_d1", 32'(seg1), 32'h66);
        runTo(242); chk("lz_d2_an", 32'(an1), 32'd0);
        chk("lz_d2_seg", 32'(seg1), 32'h00);
        chk("nolz_d2", 32'(seg0), 32'h3F);
        runTo(250); chk("lz_d3_an", 32'(an1), 32'd0);
        offer(16'h0000);
        runTo(258); chk("lz0_d0", 32'(seg1), 32'h3F);
        runTo(266); chk("lz0_d1_an", 32'(an1), 32'd0);

        // Reset mid-operation with a pending value
        runTo(262);
        offer(16'hFFFF);
        runTo(290);
        offer(16'h1234);
        runTo(300);
        chk("pre_rst_seg", 32'(seg0), 32'h71);
        chk("pre_rst_ready", 32'(ready0), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_ready", 32'(ready0), 32'd1);
        runTo(2);  chk("mid_rst_d0", 32'(seg0), 32'h3F);
        runTo(26); chk("mid_rst_d3", 32'(seg0), 32'h3F);
        runTo(98); chk("no_pend_leak", 32'(seg0), 32'h3F);

        // Random offers held until accepted, with rare resets
        for (int i = 0; i < 2500; i++) begin
            if (!valid && ($urandom_range(0, 5) == 0)) begin
                valid = 1'b1;
                value = 16'($urandom);
            end
            rst = ($urandom_range(0, 599) == 0);
            step();
            if (lastAcc) valid = 1'b0;
        end
        rst   = 1'b0;
        valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
